regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port (wrt_en/oprd/wrt_data) between the two writeback

---
 rtl/rv32i_pkg.sv | 12 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 81 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared writeback types: register/data widths, round-robin state and request record.
package rv32i_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {LAST_ALU = 1'b0, LAST_LSU = 1'b1} wb_rr_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant between ALU (req[0]) and LSU (req[1]) with its history flop.
//  state    | meaning
//  LAST_ALU | ALU won the most recent grant; LSU has priority next
//  LAST_LSU | LSU won the most recent grant (reset); ALU has priority next
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   import rv32i_pkg::*;

   wb_rr_e r_state;
   wb_rr_e w_state_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= LAST_LSU;
      else     r_state <= w_state_nxt;
   end

   // Grants are suppressed during reset so no requester sees a false ack.
   always_comb begin
      w_state_nxt = r_state;
      o_gnt       = 2'b00;
      if (!rst) begin
         case (r_state)
            LAST_ALU: begin
               if (i_req[1]) begin
                  o_gnt       = 2'b10;
                  w_state_nxt = LAST_LSU;
               end else if (i_req[0]) begin
                  o_gnt       = 2'b01;
                  w_state_nxt = LAST_ALU;
               end
            end
            default: begin
               if (i_req[0]) begin
                  o_gnt       = 2'b01;
                  w_state_nxt = LAST_ALU;
               end else if (i_req[1]) begin
                  o_gnt       = 2'b10;
                  w_state_nxt = LAST_LSU;
               end
            end
         endcase
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU writebacks, one registered write per cycle.
// Define RF_BYPASS_EN to add combinational write-to-read forwarding of the staged write.
module regfile_wb_arbiter #(
   parameter int XLEN       = rv32i_pkg::XLEN,
   parameter int REG_ADDR_W = rv32i_pkg::REG_ADDR_W,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   output logic                  lsu_ready,
   output logic                  wrt_en,
   output logic [REG_ADDR_W-1:0] oprd,
   output logic [XLEN-1:0]       wrt_data,
   output logic [CNT_W-1:0]      conflicts
`ifdef RF_BYPASS_EN
   ,
   input  logic [REG_ADDR_W-1:0] oprs1,
   input  logic [REG_ADDR_W-1:0] oprs2,
   input  logic [XLEN-1:0]       rf_rs1,
   input  logic [XLEN-1:0]       rf_rs2,
   output logic [XLEN-1:0]       rs1,
   output logic [XLEN-1:0]       rs2
`endif
);
   import rv32i_pkg::*;

   logic [1:0]            w_gnt;
   wb_req_t               w_sel;
   logic                  r_wrt_en;
   logic [REG_ADDR_W-1:0] r_oprd;
   logic [XLEN-1:0]       r_wrt_data;
   logic [CNT_W-1:0]      r_conflicts;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req ({lsu_valid, alu_valid}),
      .o_gnt (w_gnt)
   );

   assign alu_ready = w_gnt[0];
   assign lsu_ready = w_gnt[1];
   assign w_sel     = w_gnt[1] ? '{rd: lsu_rd, data: lsu_data} : '{rd: alu_rd, data: alu_data};

   // x0 grants still capture rd/data but never raise the write enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrt_en   <= 1'b0;
         r_oprd     <= '0;
         r_wrt_data <= '0;
      end else if (|w_gnt) begin
         r_wrt_en   <= (w_sel.rd != '0);
         r_oprd     <= w_sel.rd;
         r_wrt_data <= w_sel.data;
      end else begin
         r_wrt_en   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         r_conflicts <= '0;
      else if (alu_valid && lsu_valid && ~&r_conflicts) r_conflicts <= r_conflicts + 1'b1;
   end

   assign wrt_en    = r_wrt_en;
   assign oprd      = r_oprd;
   assign wrt_data  = r_wrt_data;
   assign conflicts = r_conflicts;

`ifdef RF_BYPASS_EN
   assign rs1 = (r_wrt_en && r_oprd == oprs1 && r_oprd != '0) ? r_wrt_data : rf_rs1;
   assign rs2 = (r_wrt_en && r_oprd == oprs2 && r_oprd != '0) ? r_wrt_data : rf_rs2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_regfile_wb_arbiter;
   localparam int XW   = 32;
   localparam int AW   = 5;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          av, lv;
   logic [AW-1:0] ard, lrd;
   logic [XW-1:0] adat, ldat;
   logic          a_rdy, l_rdy, wen;
   logic [AW-1:0] oprd;
   logic [XW-1:0] wdat;
   logic [CW-1:0] conf;
`ifdef RF_BYPASS_EN
   logic [AW-1:0] oprs1, oprs2;
   logic [XW-1:0] rf_rs1, rf_rs2, rs1, rs2;
`endif

   int n_pass = 0;
   int n_total = 0;

   // Transaction-level model: who won last, and what the write port should show.
   bit            m_last_lsu;
   bit            m_wen;
   logic [AW-1:0] m_oprd;
   logic [XW-1:0] m_wdat;
   int            m_conf;

   regfile_wb_arbiter #(.XLEN(XW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(av), .alu_rd(ard), .alu_data(adat), .alu_ready(a_rdy),
      .lsu_valid(lv), .lsu_rd(lrd), .lsu_data(ldat), .lsu_ready(l_rdy),
      .wrt_en(wen), .oprd(oprd), .wrt_data(wdat), .conflicts(conf)
`ifdef RF_BYPASS_EN
      , .oprs1(oprs1), .oprs2(oprs2), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rs1(rs1), .rs2(rs2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit exp_ga();
      return av && (!lv || m_last_lsu);
   endfunction

   function automatic bit exp_gl();
      return lv && (!av || !m_last_lsu);
   endfunction

   // Advance one clock, applying the current inputs to the model first.
   task automatic tick();
      bit ga, gl;
      ga = exp_ga();
      gl = exp_gl();
      if (av && lv && m_conf < MAXC) m_conf++;
      if (ga) begin
         m_wen = (ard != 0); m_oprd = ard; m_wdat = adat; m_last_lsu = 1'b0;
      end else if (gl) begin
         m_wen = (lrd != 0); m_oprd = lrd; m_wdat = ldat; m_last_lsu = 1'b1;
      end else begin
         m_wen = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_last_lsu = 1'b1; m_wen = 1'b0; m_oprd = '0; m_wdat = '0; m_conf = 0;
   endtask

   task automatic reset_dut();
      av = 0; lv = 0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      av = 1; lv = 1; ard = 3; lrd = 4; adat = 1; ldat = 2;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      n_total++; if (wen !== 1'b0) $display("FAIL reset_wen got %0b want 0", wen); else n_pass++;
      n_total++; if (oprd !== '0) $display("FAIL reset_oprd got %0d want 0", oprd); else n_pass++;
      n_total++; if (wdat !== '0) $display("FAIL reset_wdata got %0h want 0", wdat); else n_pass++;
      n_total++; if (conf !== '0) $display("FAIL reset_conflicts got %0d want 0", conf); else n_pass++;
      n_total++;
      if (a_rdy !== 1'b0 || l_rdy !== 1'b0)
         $display("FAIL reset_ready got %0b%0b want 00", a_rdy, l_rdy);
      else n_pass++;
      av = 0; lv = 0;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_alu_only();
      reset_dut();
      av = 1; ard = 6; adat = 9; #1;
      n_total++;
      if (a_rdy !== 1'b1 || l_rdy !== 1'b0) $display("FAIL alu_only_ready got %0b%0b want 01", l_rdy, a_rdy);
      else n_pass++;
      tick(); av = 0; #1;
      n_total++;
      if (wen !== 1'b1 || oprd !== 5'd6 || wdat !== 32'd9)
         $display("FAIL alu_only_write got en=%0b rd=%0d d=%0d want en=1 rd=6 d=9", wen, oprd, wdat);
      else n_pass++;
      tick();
      n_total++;
      if (wen !== 1'b0 || oprd !== 5'd6 || wdat !== 32'd9)
         $display("FAIL alu_only_hold got en=%0b rd=%0d d=%0d want en=0 rd=6 d=9", wen, oprd, wdat);
      else n_pass++;
   endtask

   task automatic test_conflict();
      reset_dut();
      av = 1; ard = 8; adat = 7; lv = 1; lrd = 5; ldat = 11; #1;
      n_total++;
      if (a_rdy !== 1'b1 || l_rdy !== 1'b0) $display("FAIL conflict_c0 got lsu/alu=%0b%0b want 01", l_rdy, a_rdy);
      else n_pass++;
      tick(); av = 0; #1;
      n_total++;
      if (wen !== 1'b1 || oprd !== 5'd8 || wdat !== 32'd7)
         $display("FAIL conflict_w0 got en=%0b rd=%0d d=%0d want en=1 rd=8 d=7", wen, oprd, wdat);
      else n_pass++;
      n_total++;
      if (a_rdy !== 1'b0 || l_rdy !== 1'b1) $display("FAIL conflict_c1 got lsu/alu=%0b%0b want 10", l_rdy, a_rdy);
      else n_pass++;
      tick(); lv = 0; #1;
      n_total++;
      if (wen !== 1'b1 || oprd !== 5'd5 || wdat !== 32'd11)
         $display("FAIL conflict_w1 got en=%0b rd=%0d d=%0d want en=1 rd=5 d=11", wen, oprd, wdat);
      else n_pass++;
      n_total++; if (conf !== 4'd1) $display("FAIL conflict_count got %0d want 1", conf); else n_pass++;
   endtask

   task automatic test_fairness();
      bit prev_alu;
      reset_dut();
      av = 1; lv = 1;
      ard = 1 + AW'($urandom_range(0, 30)); adat = $urandom;
      lrd = 1 + AW'($urandom_range(0, 30)); ldat = $urandom;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_total++;
         if (a_rdy !== (i % 2 == 0) || l_rdy !== (i % 2 == 1))
            $display("FAIL fairness_grant%0d got lsu/alu=%0b%0b want alu=%0b", i, l_rdy, a_rdy, (i % 2 == 0));
         else n_pass++;
         if (i > 0) begin
            n_total++;
            if (a_rdy === prev_alu) $display("FAIL fairness_repeat%0d got alu=%0b want %0b", i, a_rdy, !prev_alu);
            else n_pass++;
         end
         prev_alu = a_rdy;
         tick();
         n_total++;
         if (wen !== 1'b1 || oprd !== m_oprd || wdat !== m_wdat)
            $display("FAIL fairness_write%0d got rd=%0d d=%0h want rd=%0d d=%0h", i, oprd, wdat, m_oprd, m_wdat);
         else n_pass++;
         if (i % 2 == 0) begin ard = 1 + AW'($urandom_range(0, 30)); adat = $urandom; end
         else            begin lrd = 1 + AW'($urandom_range(0, 30)); ldat = $urandom; end
      end
      av = 0; lv = 0;
      tick();
      n_total++; if (conf !== 4'd6) $display("FAIL fairness_count got %0d want 6", conf); else n_pass++;
   endtask

   task automatic test_x0();
      reset_dut();
      av = 1; ard = 2; adat = 3;
      tick(); av = 0;
      lv = 1; lrd = 0; ldat = 32'hDEAD; #1;
      n_total++;
      if (l_rdy !== 1'b1 || a_rdy !== 1'b0) $display("FAIL x0_ready got lsu/alu=%0b%0b want 10", l_rdy, a_rdy);
      else n_pass++;
      tick(); lv = 0; #1;
      n_total++; if (wen !== 1'b0) $display("FAIL x0_wen got %0b want 0", wen); else n_pass++;
      av = 1; ard = 4; adat = 5; lv = 1; lrd = 6; ldat = 7; #1;
      n_total++;
      if (a_rdy !== 1'b1 || l_rdy !== 1'b0) $display("FAIL x0_rrstate got lsu/alu=%0b%0b want 01", l_rdy, a_rdy);
      else n_pass++;
      tick(); av = 0; lv = 0;
   endtask

   task automatic test_reset_midop();
      reset_dut();
      lv = 1; lrd = 9; ldat = 33;
      tick();
      n_total++; if (wen !== 1'b1) $display("FAIL midop_pre got %0b want 1", wen); else n_pass++;
      av = 1; ard = 12; adat = 44;
      #2; rst = 1'b1; model_reset(); #1;
      n_total++; if (wen !== 1'b0) $display("FAIL midop_wen got %0b want 0", wen); else n_pass++;
      n_total++;
      if (a_rdy !== 1'b0 || l_rdy !== 1'b0) $display("FAIL midop_ready got %0b%0b want 00", l_rdy, a_rdy);
      else n_pass++;
      @(posedge clk); #1;
      n_total++; if (wen !== 1'b0) $display("FAIL midop_held got %0b want 0", wen); else n_pass++;
      rst = 1'b0; #1;
      n_total++;
      if (a_rdy !== 1'b1 || l_rdy !== 1'b0) $display("FAIL midop_first got lsu/alu=%0b%0b want 01", l_rdy, a_rdy);
      else n_pass++;
      tick(); av = 0; lv = 0;
   endtask

   task automatic test_saturation();
      reset_dut();
      av = 1; lv = 1; ard = 1; lrd = 2; adat = 0; ldat = 0;
      for (int i = 0; i < MAXC + 5; i++) begin
         if (i == MAXC - 1) begin
            n_total++;
            if (conf !== CW'(MAXC - 1)) $display("FAIL sat_pre got %0d want %0d", conf, MAXC - 1); else n_pass++;
         end
         tick();
      end
      av = 0; lv = 0;
      n_total++; if (conf !== CW'(MAXC)) $display("FAIL sat_hold got %0d want %0d", conf, MAXC); else n_pass++;
   endtask

   task automatic test_random();
      bit a_pend, l_pend, ga, gl;
      reset_dut();
      a_pend = 0; l_pend = 0;
      for (int i = 0; i < 400; i++) begin
         if (!a_pend) begin av = ($urandom % 3) != 0; ard = AW'($urandom); adat = $urandom; end
         if (!l_pend) begin lv = ($urandom % 3) != 0; lrd = AW'($urandom); ldat = $urandom; end
         #1;
         ga = exp_ga(); gl = exp_gl();
         n_total++;
         if (a_rdy !== ga || l_rdy !== gl)
            $display("FAIL rand_ready%0d got lsu/alu=%0b%0b want %0b%0b", i, l_rdy, a_rdy, gl, ga);
         else n_pass++;
         a_pend = av && !ga;
         l_pend = lv && !gl;
         tick();
         n_total++;
         if (wen !== m_wen || (m_wen && (oprd !== m_oprd || wdat !== m_wdat)) || conf !== CW'(m_conf))
            $display("FAIL rand_out%0d got en=%0b rd=%0d d=%0h c=%0d want en=%0b rd=%0d d=%0h c=%0d",
                     i, wen, oprd, wdat, conf, m_wen, m_oprd, m_wdat, m_conf);
         else n_pass++;
      end
      av = 0; lv = 0;
   endtask

`ifdef RF_BYPASS_EN
   task automatic test_bypass();
      reset_dut();
      av = 1; ard = 6; adat = 9;
      tick(); av = 0;
      oprs1 = 6; rf_rs1 = 0; oprs2 = 7; rf_rs2 = 32'h55; #1;
      n_total++; if (rs1 !== 32'd9) $display("FAIL bypass_hit got %0h want 9", rs1); else n_pass++;
      n_total++; if (rs2 !== 32'h55) $display("FAIL bypass_miss got %0h want 55", rs2); else n_pass++;
      oprs1 = 0; rf_rs1 = 32'h1234; #1;
      n_total++; if (rs1 !== 32'h1234) $display("FAIL bypass_x0 got %0h want 1234", rs1); else n_pass++;
      tick();
      oprs2 = 6; rf_rs2 = 32'h77; #1;
      n_total++; if (rs2 !== 32'h77) $display("FAIL bypass_idle got %0h want 77", rs2); else n_pass++;
   endtask
`endif

   initial begin
      rst = 1'b0; av = 0; lv = 0; ard = '0; lrd = '0; adat = '0; ldat = '0;
`ifdef RF_BYPASS_EN
      oprs1 = '0; oprs2 = '0; rf_rs1 = '0; rf_rs2 = '0;
`endif
      #2;
      test_reset();
      test_alu_only();
      test_conflict();
      test_fairness();
      test_x0();
      test_reset_midop();
      test_saturation();
      test_random();
`ifdef RF_BYPASS_EN
      test_bypass();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
